display_scan_ctrl: RTL and testbench
====================================

// Module: display_scan_ctrl
// PURPOSE
//  Accepts a signed value, converts it to sign/tens/units with a sequential divide-by-10 FSM,
//  and time-multiplexes one shared deco7seg instance across three digits (units, tens, sign).
//  Sits between the arithmetic datapath and the single 7-seg decoder/anode pins of the board.
//  Provides a valid/ready load handshake and glitch-free digit scanning.
// PARAMETERS
//  REFRESH_DIV  50_000  clk cycles each digit stays enabled (>=2)
//  NUM_DIGITS   3       scanned positions; fixed at 3 (0=units, 1=tens, 2=sign)
// PORTS
//  clk        in   1  system clock, all state on rising edge
//  reset_n    in   1  asynchronous active-low reset
//  val_in     in   8  signed two's-complement value to display
//  val_valid  in   1  val_in offered this cycle
//  val_ready  out  1  controller can accept val_in (high in IDLE)
//  dec_d      out  4  to deco7seg D
//  dec_tens   out  4  to deco7seg tens
//  dec_flag   out  1  to deco7seg Flag (1 = negative)
//  dec_sel    out  1  to deco7seg deco (zero-extended to int at instantiation)
//  an_n       out  3  active-low digit enables, bit i = position i
// BEHAVIOUR
//  Reset: FSM=IDLE, val_ready=1, stored sign/tens/units=0, digit idx=0, prescaler=0,
//   an_n=3'b110, dec_d=0, dec_tens=4'hF, dec_flag=0, dec_sel=0 (shows "0" on units).
//  Handshake: transfer when val_valid&&val_ready; val_ready drops the next cycle, returns
//   high the cycle after commit. val_valid while !val_ready is ignored, never queued.
//  FSM IDLE->ABS->DIV->COMMIT->IDLE:
//   ABS: capture neg=val_in[7]; mag=|val_in| in 8 bits (-128 -> 128); mag>99 saturates to 99.
//   DIV: per cycle, if mag>=10 {mag-=10; tens_acc++} else go COMMIT. Max 9 DIV iterations.
//   COMMIT: one cycle; sign/tens/units registers updated atomically (units=mag[3:0]).
//   Latency: accept to new digits visible = 3+tens cycles (3..12). Display shows old value
//   until COMMIT; never a partial value.
//  Zero: val_in=0 -> neg=0 (no "-0").
//  Scan: prescaler counts 0..REFRESH_DIV-1; at wrap idx advances 0->1->2->0.
//   an_n, dec_* are registered and change together on the idx-advance edge only.
//  Per-position drive (stored neg N, tens T, units U):
//   idx0 units: dec_d=U, dec_tens=4'hF, dec_flag=N, dec_sel=0  -> always shows U
//   idx1 tens : dec_d=T, dec_tens=T,    dec_flag=N, dec_sel=0  -> blank when T==0
//   idx2 sign : dec_d=4'hF, dec_tens=T, dec_flag=N, dec_sel=1  -> '-' if N, else blank
//  Exactly one an_n bit low at all times after reset.
//  Simultaneous: COMMIT coinciding with idx advance -> new digits used on that same edge.
//  Reset mid-conversion: abandons conversion, returns to reset state above asynchronously.
// STRUCTURE
//  Shared package disp_pkg: state enum (IDLE, ABS, DIV, COMMIT), position localparams
//   POS_UNITS/POS_TENS/POS_SIGN, BLANK_CODE=4'hF, MAX_MAG=99.
//  One sub-module natural: scan_timer (prescaler + 2-bit idx ring, emits advance pulse).
//  deco7seg is instantiated by the parent, not inside this block.
// TESTING
//  Reset then idle, REFRESH_DIV=4 -> an_n cycles 110,101,011 every 4 clk; units dec_d=0.
//  Load 8'sd47 -> val_ready low 7 cycles; then U=7,T=4,N=0; sign pos dec_d=F, dec_sel=1.
//  Load -8'sd5 -> U=5,T=0,N=1; tens pos dec_tens=0 (blank), sign pos dec_flag=1 (minus).
//  Load 8'sd120 and -8'sd128 -> both saturate to 99, N=0 resp. N=1; latency 12 cycles.
//  val_valid held high during DIV with new value -> ignored; only first value displayed.
//  Assert reset_n low mid-DIV -> outputs immediately reset values; next load converts cleanly.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Digit positions, FSM states and saturation helper.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ABS,
        DIV,
        COMMIT
    } state_t;

    localparam logic [1:0] POS_UNITS = 2'd0;
    localparam logic [1:0] POS_TENS  = 2'd1;
    localparam logic [1:0] POS_SIGN  = 2'd2;

    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam logic [7:0] MAX_MAG    = 8'd99;

    // -128 folds to 128 in 8 unsigned bits, then clamps like any value > 99
    function automatic logic [7:0] abs_sat(input logic [7:0] v);
        logic [7:0] m;
        m = v[7] ? (~v + 8'd1) : v;
        return (m > MAX_MAG) ? MAX_MAG : m;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Refresh prescaler and digit index ring for display scanning.
// adv pulses on the last prescaler count; nidx is the index taken then.
module scan_timer
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50_000
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       adv,
    output logic [1:0] nidx
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;

    assign adv  = (cnt == LAST);
    assign nidx = (idx == POS_SIGN) ? POS_UNITS : idx + 2'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            idx <= POS_UNITS;
        end else if (adv) begin
            cnt <= '0;
            idx <= nidx;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Signed value to sign/tens/units converter with a multiplexed
// drive for one shared 7-segment decoder across three digits.
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50_000,
    parameter int NUM_DIGITS  = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            val_in,
    input  logic                  val_valid,
    output logic                  val_ready,
    output logic [3:0]            dec_d,
    output logic [3:0]            dec_tens,
    output logic                  dec_flag,
    output logic                  dec_sel,
    output logic [NUM_DIGITS-1:0] an_n
);

    state_t     state;
    logic [7:0] raw_q;
    logic [7:0] mag;
    logic [3:0] tens_acc;
    logic       neg_acc;
    logic       neg_q;
    logic [3:0] tens_q;
    logic [3:0] units_q;

    logic       adv;
    logic [1:0] nidx;

    logic                  n_neg;
    logic [3:0]            n_tens;
    logic [3:0]            n_units;
    logic [3:0]            nx_d;
    logic [3:0]            nx_tens;
    logic                  nx_sel;
    logic [NUM_DIGITS-1:0] nx_an;

    scan_timer #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_scan (
        .clk    (clk),
        .reset_n(reset_n),
        .adv    (adv),
        .nidx   (nidx)
    );

    // Bypass stored digits during COMMIT so a coinciding advance shows the new value
    always_comb begin
        n_neg   = (state == COMMIT) ? neg_acc   : neg_q;
        n_tens  = (state == COMMIT) ? tens_acc  : tens_q;
        n_units = (state == COMMIT) ? mag[3:0]  : units_q;
        nx_d    = n_units;
        nx_tens = BLANK_CODE;
        nx_sel  = 1'b0;
        nx_an   = '1;
        nx_an[nidx] = 1'b0;
        case (nidx)
            POS_TENS: begin
                nx_d    = n_tens;
                nx_tens = n_tens;
            end
            POS_SIGN: begin
                nx_d    = BLANK_CODE;
                nx_tens = n_tens;
                nx_sel  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            val_ready <= 1'b1;
            raw_q     <= '0;
            mag       <= '0;
            tens_acc  <= '0;
            neg_acc   <= 1'b0;
            neg_q     <= 1'b0;
            tens_q    <= '0;
            units_q   <= '0;
            an_n      <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
            dec_d     <= '0;
            dec_tens  <= BLANK_CODE;
            dec_flag  <= 1'b0;
            dec_sel   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (val_valid) begin
                        raw_q     <= val_in;
                        val_ready <= 1'b0;
                        state     <= ABS;
                    end
                end
                ABS: begin
                    neg_acc  <= raw_q[7];
                    mag      <= abs_sat(raw_q);
                    tens_acc <= '0;
                    state    <= DIV;
                end
                DIV: begin
                    if (mag >= 8'd10) begin
                        mag      <= mag - 8'd10;
                        tens_acc <= tens_acc + 4'd1;
                    end else begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    neg_q     <= neg_acc;
                    tens_q    <= tens_acc;
                    units_q   <= mag[3:0];
                    val_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
            if (adv) begin
                an_n     <= nx_an;
                dec_d    <= nx_d;
                dec_tens <= nx_tens;
                dec_flag <= n_neg;
                dec_sel  <= nx_sel;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a short refresh period.
// Vector table of loads plus hand sequences for hold and reset cases.
module tb_display_scan_ctrl;

    typedef struct {
        logic [7:0] val;
        logic       neg;
        logic [3:0] tens;
        logic [3:0] units;
        int         lat;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] val_in = '0;
    logic       val_valid = 1'b0;
    logic       val_ready;
    logic [3:0] dec_d;
    logic [3:0] dec_tens;
    logic       dec_flag;
    logic       dec_sel;
    logic [2:0] an_n;

    int checks = 0;
    int failures = 0;

    display_scan_ctrl #(
        .REFRESH_DIV(4),
        .NUM_DIGITS (3)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .val_in   (val_in),
        .val_valid(val_valid),
        .val_ready(val_ready),
        .dec_d    (dec_d),
        .dec_tens (dec_tens),
        .dec_flag (dec_flag),
        .dec_sel  (dec_sel),
        .an_n     (an_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!val_ready && n < 30) begin
            n++;
            @(negedge clk);
        end
        if (!val_ready) chk("ready_timeout", 32'(val_ready), 32'd1);
    endtask

    task automatic wait_adv();
        logic [2:0] a0 = an_n;
        int n = 0;
        while (an_n == a0 && n < 10) begin
            n++;
            @(negedge clk);
        end
        if (an_n == a0) chk("adv_timeout", 32'(an_n), 32'(~a0));
    endtask

    task automatic check_display(input string nm, input logic n,
                                 input logic [3:0] t, input logic [3:0] u);
        logic [9:0] exp;
        logic [2:0] want;
        int k;
        wait_adv();
        for (int p = 0; p < 3; p++) begin
            want = ~(3'b001 << p);
            k = 0;
            while (an_n != want && k < 16) begin
                k++;
                @(negedge clk);
            end
            case (p)
                0: exp = {u, 4'hF, n, 1'b0};
                1: exp = {t, t, n, 1'b0};
                default: exp = {4'hF, t, n, 1'b1};
            endcase
            chk($sformatf("%s_pos%0d_an", nm, p), 32'(an_n), 32'(want));
            chk($sformatf("%s_pos%0d_dec", nm, p),
                32'({dec_d, dec_tens, dec_flag, dec_sel}), 32'(exp));
        end
    endtask

    task automatic load_check(input string nm, input vec_t v);
        int cnt = 0;
        wait_ready();
        val_in = v.val;
        val_valid = 1'b1;
        @(negedge clk);
        val_valid = 1'b0;
        while (!val_ready && cnt < 30) begin
            cnt++;
            @(negedge clk);
        end
        chk({nm, "_latency"}, 32'(cnt), 32'(v.lat));
        check_display(nm, v.neg, v.tens, v.units);
    endtask

    vec_t tbl[7];

    initial begin
        int cnt;
        tbl[0] = '{8'sd47,   1'b0, 4'd4, 4'd7, 7};
        tbl[1] = '{-8'sd5,   1'b1, 4'd0, 4'd5, 3};
        tbl[2] = '{8'sd120,  1'b0, 4'd9, 4'd9, 12};
        tbl[3] = '{8'h80,    1'b1, 4'd9, 4'd9, 12};
        tbl[4] = '{8'sd0,    1'b0, 4'd0, 4'd0, 3};
        tbl[5] = '{-8'sd99,  1'b1, 4'd9, 4'd9, 12};
        tbl[6] = '{8'sd10,   1'b0, 4'd1, 4'd0, 4};

        #12;
        @(negedge clk);
        chk("rst_an", 32'(an_n), 32'(3'b110));
        chk("rst_dec", 32'({dec_d, dec_tens, dec_flag, dec_sel}),
            32'({4'h0, 4'hF, 1'b0, 1'b0}));
        chk("rst_ready", 32'(val_ready), 32'd1);
        reset_n = 1'b1;

        // idle scan: position advances every 4 clocks
        for (int k = 0; k <= 12; k++) begin
            logic [2:0] e;
            e = ~(3'b001 << ((k / 4) % 3));
            chk($sformatf("scan_k%0d", k), 32'(an_n), 32'(e));
            if (k % 4 == 0 && (k / 4) % 3 == 0)
                chk($sformatf("scan_units_k%0d", k), 32'(dec_d), 32'd0);
            @(negedge clk);
        end

        for (int i = 0; i < 7; i++)
            load_check($sformatf("vec%0d", i), tbl[i]);

        // valid held with a different value during conversion
        wait_ready();
        val_in = 8'sd47;
        val_valid = 1'b1;
        @(negedge clk);
        val_in = 8'sd23;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold_ready_low%0d", i), 32'(val_ready), 32'd0);
            cnt++;
            @(negedge clk);
        end
        val_valid = 1'b0;
        while (!val_ready && cnt < 30) begin
            cnt++;
            @(negedge clk);
        end
        chk("hold_latency", 32'(cnt), 32'd7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("hold_no_queue%0d", i), 32'(val_ready), 32'd1);
        end
        check_display("hold", 1'b0, 4'd4, 4'd7);

        // reset asserted mid-division of a long conversion
        val_in = -8'sd99;
        val_valid = 1'b1;
        @(negedge clk);
        val_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_an", 32'(an_n), 32'(3'b110));
        chk("midrst_dec", 32'({dec_d, dec_tens, dec_flag, dec_sel}),
            32'({4'h0, 4'hF, 1'b0, 1'b0}));
        chk("midrst_ready", 32'(val_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        load_check("postrst", '{8'sd36, 1'b0, 4'd3, 4'd6, 6});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
